// File: rtl/serial_divider_32.sv
// Multi-cycle signed divider: restoring shift-subtract, one quotient bit per clock.
// Sign correction and the divide-by-zero override are applied in a final DONE cycle.
module serial_divider_32 #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic [WIDTH-1:0] data_remainder,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [WIDTH-1:0] negate_if(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? (~v + WIDTH'(1)) : v;
  endfunction

  // Magnitude of a two's complement value; -2^(WIDTH-1) maps to its unsigned pattern.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
    return negate_if(v, v[WIDTH-1]);
  endfunction

  state_t           state_r;
  logic [CW-1:0]    count_r;
  logic [WIDTH-1:0] dvd_r;
  logic [WIDTH-1:0] div_r;
  logic [WIDTH-1:0] rem_r;
  logic             signa_r;
  logic             signb_r;
  logic             zero_r;

  logic [WIDTH:0]   shifted_s;
  logic [WIDTH:0]   diff_s;
  logic [WIDTH-1:0] step_rem_s;
  logic             step_bit_s;
  logic [WIDTH-1:0] fin_quo_s;
  logic [WIDTH-1:0] fin_rem_s;

  // One restoring step; shifted_s < 2*divisor, so bit WIDTH of diff_s is a clean borrow.
  always_comb begin
    shifted_s = {rem_r, dvd_r[WIDTH-1]};
    diff_s    = shifted_s - {1'b0, div_r};
    if (diff_s[WIDTH]) begin
      step_rem_s = shifted_s[WIDTH-1:0];
      step_bit_s = 1'b0;
    end else begin
      step_rem_s = diff_s[WIDTH-1:0];
      step_bit_s = 1'b1;
    end
  end

  // Sign-corrected results; a zero divisor suppresses the raw all-ones quotient.
  always_comb begin
    if (zero_r) begin
      fin_quo_s = WIDTH'(0);
      fin_rem_s = WIDTH'(0);
    end else begin
      fin_quo_s = negate_if(dvd_r, signa_r ^ signb_r);
      fin_rem_s = negate_if(rem_r, signa_r);
    end
  end

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r        <= IDLE;
      count_r        <= CW'(0);
      dvd_r          <= WIDTH'(0);
      div_r          <= WIDTH'(0);
      rem_r          <= WIDTH'(0);
      signa_r        <= 1'b0;
      signb_r        <= 1'b0;
      zero_r         <= 1'b0;
      data_result    <= WIDTH'(0);
      data_remainder <= WIDTH'(0);
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      if (state_r == DONE) begin
        data_result    <= fin_quo_s;
        data_remainder <= fin_rem_s;
        data_exception <= zero_r;
        data_resultRDY <= 1'b1;
      end
      // A start is honoured in every state; in DONE it coexists with the strobe above.
      if (ctrl_DIV) begin
        state_r <= RUN;
        count_r <= CW'(0);
        dvd_r   <= magnitude(data_operandA);
        div_r   <= magnitude(data_operandB);
        rem_r   <= WIDTH'(0);
        signa_r <= data_operandA[WIDTH-1];
        signb_r <= data_operandB[WIDTH-1];
        zero_r  <= (data_operandB == WIDTH'(0));
        busy    <= 1'b1;
      end else begin
        case (state_r)
          IDLE: begin
            busy <= 1'b0;
          end
          RUN: begin
            rem_r   <= step_rem_s;
            dvd_r   <= {dvd_r[WIDTH-2:0], step_bit_s};
            count_r <= count_r + CW'(1);
            if (count_r == CW'(WIDTH - 1)) begin
              state_r <= DONE;
            end else begin
              state_r <= RUN;
            end
          end
          DONE: begin
            state_r <= IDLE;
            busy    <= 1'b0;
          end
          default: begin
            state_r <= IDLE;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_serial_divider_32.sv
// Directed bench for serial_divider_32: a cycle-level arithmetic model checked every
// cycle, plus literal expectations for each test-plan vector.
module tb_serial_divider_32;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ctrl_DIV = 1'b0;
  logic [31:0] data_operandA = 32'd0;
  logic [31:0] data_operandB = 32'd0;
  logic [31:0] data_result;
  logic [31:0] data_remainder;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;

  serial_divider_32 #(.WIDTH(32)) dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_remainder (data_remainder),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic: truncating signed division, remainder follows the dividend.
  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r,
                                  output logic e);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    sa = a;
    sb = b;
    if (b == 32'd0) begin
      q = 32'd0; r = 32'd0; e = 1'b1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000; r = 32'd0; e = 1'b0;
    end else begin
      q = sa / sb; r = sa % sb; e = 1'b0;
    end
  endfunction

  // Model state: a pending operation completes 33 edges after its last start edge.
  logic        m_pend = 1'b0;
  int          m_left = 0;
  logic        m_rdy = 1'b0;
  logic [31:0] m_res = 32'd0;
  logic [31:0] m_rem = 32'd0;
  logic        m_exc = 1'b0;
  logic [31:0] m_nres = 32'd0;
  logic [31:0] m_nrem = 32'd0;
  logic        m_nexc = 1'b0;

  always @(posedge clock or posedge reset) begin : model
    int          left;
    logic        strobe;
    logic [31:0] q;
    logic [31:0] r;
    logic        e;
    if (reset) begin
      m_pend <= 1'b0;
      m_left <= 0;
      m_rdy  <= 1'b0;
      m_res  <= 32'd0;
      m_rem  <= 32'd0;
      m_exc  <= 1'b0;
    end else begin
      left   = m_left;
      strobe = 1'b0;
      if (m_pend) begin
        left   = left - 1;
        strobe = (left == 0);
      end
      m_rdy <= strobe;
      if (strobe) begin
        m_res <= m_nres;
        m_rem <= m_nrem;
        m_exc <= m_nexc;
      end
      if (ctrl_DIV) begin
        ref_div(data_operandA, data_operandB, q, r, e);
        m_nres <= q;
        m_nrem <= r;
        m_nexc <= e;
        m_pend <= 1'b1;
        m_left <= 33;
      end else begin
        m_left <= left;
        if (strobe) m_pend <= 1'b0;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clock) begin
    check("rdy", {31'd0, data_resultRDY}, {31'd0, m_rdy});
    check("busy", {31'd0, busy}, {31'd0, m_pend});
    check("result", data_result, m_res);
    check("remainder", data_remainder, m_rem);
    check("exception", {31'd0, data_exception}, {31'd0, m_exc});
  end

  // Caller sits at a negedge; the following posedge is the start edge.
  task automatic start(input logic [31:0] a, input logic [31:0] b);
    data_operandA = a;
    data_operandB = b;
    ctrl_DIV = 1'b1;
    @(negedge clock);
    ctrl_DIV = 1'b0;
  endtask

  task automatic wait_rdy(input string name, input int exp_lat, input logic [31:0] q,
                          input logic [31:0] r, input logic e);
    int lat;
    lat = 0;
    while (!data_resultRDY && lat < 40) begin
      @(negedge clock);
      lat++;
    end
    check({name, "_latency"}, lat, exp_lat);
    check({name, "_q"}, data_result, q);
    check({name, "_r"}, data_remainder, r);
    check({name, "_e"}, {31'd0, data_exception}, {31'd0, e});
  endtask

  initial begin
    @(negedge clock);
    @(negedge clock);
    check("reset_result", data_result, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    @(negedge clock);

    start(32'd100, 32'd7);
    check("busy_after_start", {31'd0, busy}, 32'd1);
    wait_rdy("100/7", 33, 32'd14, 32'd2, 1'b0);
    @(negedge clock);
    check("rdy_drops", {31'd0, data_resultRDY}, 32'd0);
    check("hold_q", data_result, 32'd14);

    start(32'hFFFF_FF9C, 32'd7);
    wait_rdy("-100/7", 33, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0);
    @(negedge clock);
    start(32'd100, 32'hFFFF_FFF9);
    wait_rdy("100/-7", 33, 32'hFFFF_FFF2, 32'd2, 1'b0);
    @(negedge clock);

    start(32'd12345, 32'd0);
    wait_rdy("div0", 33, 32'd0, 32'd0, 1'b1);
    @(negedge clock);
    start(32'd9, 32'd3);
    check("exc_held_on_start", {31'd0, data_exception}, 32'd1);
    wait_rdy("9/3", 33, 32'd3, 32'd0, 1'b0);
    @(negedge clock);

    start(32'h8000_0000, 32'hFFFF_FFFF);
    wait_rdy("ovf", 33, 32'h8000_0000, 32'd0, 1'b0);
    @(negedge clock);
    start(32'h8000_0000, 32'd1);
    wait_rdy("min/1", 33, 32'h8000_0000, 32'd0, 1'b0);
    @(negedge clock);

    // Abort: re-pulse nine cycles in; only the second operation may strobe.
    start(32'd100, 32'd7);
    repeat (8) @(negedge clock);
    start(32'd50, 32'd5);
    wait_rdy("abort", 33, 32'd10, 32'd0, 1'b0);
    @(negedge clock);

    // Start coinciding with the DONE edge: old strobe plus new operation.
    start(32'd9, 32'd3);
    repeat (32) @(negedge clock);
    start(32'd20, 32'hFFFF_FFFA);
    check("done_restart_rdy", {31'd0, data_resultRDY}, 32'd1);
    check("done_restart_q", data_result, 32'd3);
    check("done_restart_busy", {31'd0, busy}, 32'd1);
    @(negedge clock);
    wait_rdy("20/-6", 32, 32'hFFFF_FFFD, 32'd2, 1'b0);
    @(negedge clock);

    // Reset mid-run.
    start(32'd100, 32'd7);
    repeat (13) @(negedge clock);
    reset = 1'b1;
    #1;
    check("midrun_busy", {31'd0, busy}, 32'd0);
    check("midrun_q", data_result, 32'd0);
    check("midrun_r", data_remainder, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    repeat (40) @(negedge clock);
    check("no_rdy_after_reset", {31'd0, data_resultRDY}, 32'd0);
    start(32'd21, 32'd4);
    wait_rdy("21/4", 33, 32'd5, 32'd1, 1'b0);
    repeat (3) @(negedge clock);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/serial_divider_32.md
Name: serial_divider_32

Overview:
- Multi-cycle signed 32-bit integer divider for the ALU/multdiv datapath.
- Sits beside the combinational logic units (bitwise and/or, adder) under the multdiv wrapper.
- Takes a one-cycle start pulse and produces one quotient bit per cycle using restoring shift-subtract.
- Returns quotient, remainder, a divide-by-zero exception flag, and a one-cycle ready strobe.

Parameters:
- WIDTH, 32, operand/result width in bits; latency scales as WIDTH+1.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- ctrl_DIV  input  1  start pulse; operands are sampled on the same edge.
- data_operandA  input  WIDTH  dividend, two's complement.
- data_operandB  input  WIDTH  divisor, two's complement.
- data_result  output  WIDTH  quotient.
- data_remainder  output  WIDTH  remainder.
- data_exception  output  1  divide-by-zero flag.
- data_resultRDY  output  1  one-cycle ready strobe.
- busy  output  1  high while an operation is in flight.

Behaviour:
- Reset (async, any state): state=IDLE; count=0. data_result, data_remainder, data_exception, data_resultRDY and busy are all 0.
- States: IDLE, RUN, DONE.
- IDLE: on an edge with ctrl_DIV=1:
  - latch |A| into the dividend shift register and |B| into the divisor register;
  - latch signA, signB, and zero flag (B==0);
  - clear the partial remainder; count=0; go to RUN.
- RUN, each edge:
  - shift {partial remainder, dividend} left by 1;
  - trial-subtract the divisor, using a WIDTH+1-bit subtraction;
  - if the difference is non-negative, keep it and set quotient LSB=1; otherwise restore and set LSB=0;
  - count++. After the step with count==WIDTH-1, go to DONE.
- DONE, one edge:
  - register the sign-corrected outputs: quotient negated iff signA^signB; remainder negated iff signA (remainder takes the sign of the dividend; truncation toward zero);
  - data_resultRDY=1 for exactly this one cycle; go to IDLE.
- Latency: start edge E0. data_resultRDY is high in the cycle after edge E0+WIDTH+1, i.e. 33 cycles for WIDTH=32, including the divide-by-zero case (fixed latency).
- busy: 1 from the cycle after E0 through the cycle before data_resultRDY rises.
- Divide by zero: data_result=0, data_remainder=0, data_exception=1. The raw all-ones quotient is suppressed.
- Overflow, -2^(WIDTH-1) / -1: data_result=0x80000000 (wraps), data_remainder=0, data_exception=0.
- Magnitude of -2^(WIDTH-1): the unsigned value 0x80000000 is handled correctly by the WIDTH+1-bit subtraction.
- Output hold: data_result, data_remainder and data_exception hold their last values until the next DONE. data_exception is never cleared by a new start; it is overwritten at the next DONE.
- ctrl_DIV=1 while in RUN: abort the current operation and restart from the new operands (same as the IDLE start edge). No ready strobe for the aborted operation.
- ctrl_DIV=1 in DONE: the DONE completes normally (ready strobe issued), and the new start is accepted on the same edge (next state RUN, not IDLE).
- ctrl_DIV held high across multiple cycles: each edge restarts the operation. Results appear 33 cycles after the last high edge.
- Reset asserted mid-RUN: immediate return to IDLE, all outputs 0, no strobe.

Test Plan:
- A=100, B=7, pulse ctrl_DIV → after 33 cycles RDY=1 one cycle; result=14, remainder=2, exception=0; RDY=0 on the next cycle and values held.
- A=-100 (0xFFFFFF9C), B=7 → result=-14 (0xFFFFFFF2), remainder=-2 (0xFFFFFFFE). Also A=100, B=-7 → result=-14, remainder=2.
- A=12345, B=0 → at cycle 33: result=0, remainder=0, exception=1. A following 9/3 gives result=3, exception=0.
- A=0x80000000, B=0xFFFFFFFF → result=0x80000000, exception=0. A=0x80000000, B=1 → result=0x80000000, remainder=0.
- Start 100/7, re-pulse ctrl_DIV at cycle 10 with 50/5 → no strobe at the original cycle 33; a single strobe 33 cycles after the second pulse with result=10.
- Start 100/7, assert reset at cycle 15 for 1 cycle → busy=0 and outputs 0 immediately; no RDY ever. A subsequent 21/4 gives result=5, remainder=1 at +33.
